rotor_stage: RTL and testbench

ROTOR_STAGE -- requirements
Module: rotor_stage

---
 rtl/enigma_pkg.sv | 28 ++
 rtl/rotor_map.sv | 25 ++
 rtl/rotor_stage.sv | 87 ++++++++
 tb/tb_rotor_stage.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared letter type, rotor wiring tables and small helpers for the rotor stage.
package enigma_pkg;

  typedef logic [4:0] letter_t;

  localparam int NUM_LETTERS = 26;

  localparam letter_t W1 [NUM_LETTERS] = '{
    5'd10, 5'd7,  5'd4,  5'd17, 5'd15, 5'd24, 5'd21, 5'd19, 5'd3,  5'd1,
    5'd13, 5'd9,  5'd6,  5'd18, 5'd22, 5'd20, 5'd16, 5'd14, 5'd5,  5'd23,
    5'd11, 5'd2,  5'd12, 5'd26, 5'd25, 5'd8
  };

  localparam letter_t W2 [NUM_LETTERS] = '{
    5'd14, 5'd20, 5'd26, 5'd16, 5'd19, 5'd6,  5'd2,  5'd15, 5'd11, 5'd13,
    5'd23, 5'd18, 5'd3,  5'd10, 5'd4,  5'd9,  5'd22, 5'd12, 5'd1,  5'd5,
    5'd25, 5'd21, 5'd24, 5'd8,  5'd7,  5'd17
  };

  function automatic logic is_legal(input letter_t l);
    return (l >= 5'd1) && (l <= 5'd26);
  endfunction

  function automatic logic [4:0] mod26(input logic [4:0] v);
    return (v > 5'd25) ? v - 5'd26 : v;
  endfunction

endpackage

// File: rtl/rotor_map.sv
// Combinational single-rotor substitution; sel_i picks W1 (0) or W2 (1).
module rotor_map
  import enigma_pkg::*;
(
  input  logic [4:0] letter_i,
  input  logic [4:0] pos_i,
  input  logic       sel_i,
  output logic [4:0] letter_o
);

  logic [5:0] sum, k, w, diff, m;
  logic [4:0] idx;

  always_comb begin
    // 6-bit intermediates keep (L-1)+p and W-1-p+26 free of overflow
    sum  = {1'b0, letter_i} - 6'd1 + {1'b0, pos_i};
    k    = (sum >= 6'd26) ? sum - 6'd26 : sum;
    idx  = (k < 6'd26) ? k[4:0] : 5'd0;
    w    = {1'b0, sel_i ? W2[idx] : W1[idx]};
    diff = w + 6'd25 - {1'b0, pos_i};
    m    = (diff >= 6'd26) ? diff - 6'd26 : diff;
    letter_o = m[4:0] + 5'd1;
  end

endmodule

// File: rtl/rotor_stage.sv
// Two-rotor enciphering stage with a single output register and odometer stepping.
// Optional ROTOR_LOAD_EN adds load/load_pos1/load_pos2 for direct position loading.
module rotor_stage
  import enigma_pkg::*;
#(
  parameter int INIT_POS1 = 3,
  parameter int INIT_POS2 = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [4:0] in_letter,
  output logic       in_ready,
  output logic       out_valid,
  output logic [4:0] out_letter,
  input  logic       out_ready,
`ifdef ROTOR_LOAD_EN
  input  logic       load,
  input  logic [4:0] load_pos1,
  input  logic [4:0] load_pos2,
`endif
  output logic [4:0] pos1,
  output logic [4:0] pos2
);

  localparam logic [4:0] RST_POS1 = 5'(INIT_POS1);
  localparam logic [4:0] RST_POS2 = 5'(INIT_POS2);

  logic       out_valid_q, out_valid_d;
  logic [4:0] out_letter_q, out_letter_d;
  logic [4:0] pos1_q, pos1_d, pos2_q, pos2_d;
  logic [4:0] r1_out, r2_out;
  logic       accept, legal, step;

  rotor_map u_rotor1 (.letter_i(in_letter), .pos_i(pos1_q), .sel_i(1'b0), .letter_o(r1_out));
  rotor_map u_rotor2 (.letter_i(r1_out),    .pos_i(pos2_q), .sel_i(1'b1), .letter_o(r2_out));

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign legal    = is_legal(in_letter);
  assign step     = accept && legal;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_letter_d = out_letter_q;
    pos1_d       = pos1_q;
    pos2_d       = pos2_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_letter_d = legal ? r2_out : in_letter;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
    if (step) begin
      pos1_d = (pos1_q == 5'd25) ? 5'd0 : pos1_q + 5'd1;
      if (pos1_q == 5'd25)
        pos2_d = (pos2_q == 5'd25) ? 5'd0 : pos2_q + 5'd1;
    end
`ifdef ROTOR_LOAD_EN
    // Load wins over stepping; the letter above already used pre-load positions
    if (load) begin
      pos1_d = mod26(load_pos1);
      pos2_d = mod26(load_pos2);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_letter_q <= 5'd0;
      pos1_q       <= RST_POS1;
      pos2_q       <= RST_POS2;
    end else begin
      out_valid_q  <= out_valid_d;
      out_letter_q <= out_letter_d;
      pos1_q       <= pos1_d;
      pos2_q       <= pos2_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_letter = out_letter_q;
  assign pos1       = pos1_q;
  assign pos2       = pos2_q;

endmodule

// File: tb/tb_rotor_stage.sv
// Directed bench for rotor_stage with hand-computed rotor results.
module tb_rotor_stage;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [4:0] in_letter;
  logic       in_ready;
  logic       out_valid;
  logic [4:0] out_letter;
  logic       out_ready;
  logic [4:0] pos1, pos2;
`ifdef ROTOR_LOAD_EN
  logic       load = 1'b0;
  logic [4:0] load_pos1 = 5'd0;
  logic [4:0] load_pos2 = 5'd0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rotor_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_letter(in_letter), .in_ready(in_ready),
    .out_valid(out_valid), .out_letter(out_letter), .out_ready(out_ready),
`ifdef ROTOR_LOAD_EN
    .load(load), .load_pos1(load_pos1), .load_pos2(load_pos2),
`endif
    .pos1(pos1), .pos2(pos2)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_letter = 5'd0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_letter", int'(out_letter), 0);
    chk("rst_pos1", int'(pos1), 3);
    chk("rst_pos2", int'(pos2), 7);
    chk("rst_in_ready", int'(in_ready), 1);
    step();
    rst = 1'b0;
    step();

    // a with pos 3/7 -> 18, then a with pos 4/7 -> 5
    in_valid = 1'b1; in_letter = 5'd1;
    step();
    chk("a1_valid", int'(out_valid), 1);
    chk("a1_letter", int'(out_letter), 18);
    chk("a1_pos1", int'(pos1), 4);
    chk("a1_pos2", int'(pos2), 7);
    step();
    chk("a2_letter", int'(out_letter), 5);
    chk("a2_pos1", int'(pos1), 5);
    in_valid = 1'b0;
    step();
    chk("drain_valid", int'(out_valid), 0);

    // illegal codes pass through, no stepping
    in_valid = 1'b1; in_letter = 5'd0;
    step();
    chk("ill0_letter", int'(out_letter), 0);
    chk("ill0_valid", int'(out_valid), 1);
    in_letter = 5'd31;
    step();
    chk("ill31_letter", int'(out_letter), 31);
    chk("ill_pos1", int'(pos1), 5);
    chk("ill_pos2", int'(pos2), 7);
    in_valid = 1'b0;
    step();

    // backpressure: a at pos 5/7 -> 10 held, b waits, then b at pos 6/7 -> 24
    out_ready = 1'b0; in_valid = 1'b1; in_letter = 5'd1;
    step();
    chk("stall_letter0", int'(out_letter), 10);
    chk("stall_pos1_0", int'(pos1), 6);
    in_letter = 5'd2;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", int'(in_ready), 0);
      step();
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_letter", int'(out_letter), 10);
      chk("stall_pos1", int'(pos1), 6);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", int'(in_ready), 1);
    step();
    chk("release_letter", int'(out_letter), 24);
    chk("release_valid", int'(out_valid), 1);
    chk("release_pos1", int'(pos1), 7);
    in_valid = 1'b0;
    step();
    chk("release_drain", int'(out_valid), 0);
    chk("release_no_dup_pos1", int'(pos1), 7);

    // async reset between edges discards held letter
    in_valid = 1'b1; in_letter = 5'd3;
    step();
    chk("pre_rst_valid", int'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_pos1", int'(pos1), 3);
    chk("async_rst_pos2", int'(pos2), 7);
    in_valid = 1'b0;
    #1 rst = 1'b0;
    step();
    chk("post_rst_valid", int'(out_valid), 0);

    // 26 legal letters: wrap on the 23rd accept
    in_valid = 1'b1;
    for (int i = 0; i < 26; i++) begin
      in_letter = 5'((i % 26) + 1);
      step();
      if (i == 21) begin
        chk("odo22_pos1", int'(pos1), 25);
        chk("odo22_pos2", int'(pos2), 7);
      end
      if (i == 22) begin
        chk("odo23_pos1", int'(pos1), 0);
        chk("odo23_pos2", int'(pos2), 8);
      end
    end
    chk("odo26_pos1", int'(pos1), 3);
    chk("odo26_pos2", int'(pos2), 8);
    in_valid = 1'b0;
    step();

`ifdef ROTOR_LOAD_EN
    load = 1'b1; load_pos1 = 5'd25; load_pos2 = 5'd25;
    step();
    load = 1'b0;
    chk("load_pos1", int'(pos1), 25);
    chk("load_pos2", int'(pos2), 25);
    in_valid = 1'b1; in_letter = 5'd1;
    step();
    in_valid = 1'b0;
    chk("load_step_pos1", int'(pos1), 0);
    chk("load_step_pos2", int'(pos2), 0);
    load = 1'b1; load_pos1 = 5'd27; load_pos2 = 5'd30;
    step();
    load = 1'b0;
    chk("load_mod_pos1", int'(pos1), 1);
    chk("load_mod_pos2", int'(pos2), 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
